// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module : seq_div_pkg
// Desc   : Shared types and constants for the sequential restoring divider.
// Rev    : 1.0  initial release
// ============================================================================
package seq_div_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand widths
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int COUNT_W    = 3;

  // Bidirectional pin assignments
  localparam int START_BIT   = 4;
  localparam int OUT_SEL_BIT = 5;
  localparam int BUSY_BIT    = 6;
  localparam int DONE_BIT    = 7;

  // Only busy and done are driven on the bidirectional pins
  localparam logic [7:0] UIO_OE_VAL = 8'hC0;

  // Output word for the selected view of the results
  function automatic logic [7:0] result_word(input logic                  sel,
                                             input logic [DIVIDEND_W-1:0] quot,
                                             input logic                  dz,
                                             input logic [DIVISOR_W-1:0]  rem);
    return sel ? {dz, 3'b000, rem} : quot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module : seq_restoring_divider_if
// Desc   : TinyTapeout user-project pin bundle for the divider.
// Rev    : 1.0  initial release
// ============================================================================
interface seq_restoring_divider_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  // Driver side (harness / bench)
  modport master (
    output ena, ui_in, uio_in,
    input  uio_out, uio_oe, uo_out
  );

  // Design side
  modport slave (
    input  ena, ui_in, uio_in,
    output uio_out, uio_oe, uo_out
  );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module : div_step
// Desc   : One combinational restoring-division iteration: shift in the next
//          dividend bit, subtract the divisor if it fits.
// Rev    : 1.0  initial release
// ============================================================================
module div_step
  import seq_div_pkg::*;
(
  input  wire logic [DIVISOR_W-1:0] r_in,
  input  wire logic                 dividend_bit,
  input  wire logic [DIVISOR_W-1:0] divisor,
  output logic      [DIVISOR_W-1:0] r_out,
  output logic                      q_bit
);

  logic [DIVISOR_W:0] trial;

  // Trial value is 5 bits wide; when the divisor fits, the difference is
  // smaller than the divisor so a 4-bit modular subtract is exact.
  always_comb begin
    trial = {r_in, dividend_bit};
    q_bit = (trial >= {1'b0, divisor});
    r_out = q_bit ? (trial[DIVISOR_W-1:0] - divisor) : trial[DIVISOR_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module : seq_restoring_divider
// Desc   : Sequential 8-by-4 unsigned restoring divider, one quotient bit per
//          clock, behind the TinyTapeout pin interface.
// Rev    : 1.0  initial release
// ============================================================================
module seq_restoring_divider
  import seq_div_pkg::*;
#(
  parameter logic [DIVIDEND_W-1:0] DZ_QUOT = 8'hFF,
  parameter logic [DIVISOR_W-1:0]  DZ_REM  = 4'h0
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  seq_restoring_divider_if.slave     pins
);

  state_t                state, next_state;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [COUNT_W-1:0]    count;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;   // doubles as partial remainder in RUN
  logic                  dz;

  logic                  start;
  logic                  out_sel;
  logic [DIVISOR_W-1:0]  divisor_in;
  logic                  accept;
  logic                  busy;
  logic                  done;
  logic [DIVISOR_W-1:0]  step_r;
  logic                  step_q;
  logic [7:0]            uio_out_w;
  logic                  unused_pins;

  assign start      = pins.uio_in[START_BIT];
  assign out_sel    = pins.uio_in[OUT_SEL_BIT];
  assign divisor_in = pins.uio_in[DIVISOR_W-1:0];
  assign accept     = start && (state == IDLE || state == DONE);

  // ena is always high when powered and uio_in[7:6] carry nothing
  assign unused_pins = &{pins.ena, pins.uio_in[7:6]};

  div_step u_div_step (
    .r_in         (remainder),
    .dividend_bit (dividend[count]),
    .divisor      (divisor),
    .r_out        (step_r),
    .q_bit        (step_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and status decode
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = (divisor_in == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (count == '0) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) next_state = (divisor_in == '0) ? DONE : RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latch and iterative datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend  <= '0;
      divisor   <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else if (accept) begin
      dividend <= pins.ui_in;
      divisor  <= divisor_in;
      count    <= COUNT_W'(DIVIDEND_W - 1);
      dz       <= (divisor_in == '0);
      if (divisor_in == '0) begin
        quotient  <= DZ_QUOT;
        remainder <= DZ_REM;
      end else begin
        quotient  <= '0;
        remainder <= '0;
      end
    end else if (state == RUN) begin
      quotient[count] <= step_q;
      remainder       <= step_r;
      count           <= count - 1'b1;
    end
  end

  // Pin outputs
  always_comb begin
    uio_out_w           = '0;
    uio_out_w[BUSY_BIT] = busy;
    uio_out_w[DONE_BIT] = done;
  end

  assign pins.uio_out = uio_out_w;
  assign pins.uio_oe  = UIO_OE_VAL;
  assign pins.uo_out  = result_word(out_sel, quotient, dz, remainder);

endmodule
`default_nettype wire

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential 8-bit by 4-bit unsigned restoring divider; the inverse of the team's 4x4 array multiplier.
- Takes an 8-bit dividend (e.g. a product from the multiplier) and a 4-bit divisor.
- Produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock.
- Sits behind the standard TinyTapeout user-project pin interface, with status on the bidirectional pins.

Parameters:
- DZ_QUOT, 8'hFF, quotient reported on divide-by-zero.
- DZ_REM, 4'h0, remainder reported on divide-by-zero.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  always 1 when powered; unused.
- ui_in  input  8  dividend.
- uio_in  input  8  [3:0] divisor; [4] start; [5] out_sel; [7:6] unused.
- uio_out  output  8  [6] busy; [7] done; all other bits 0.
- uio_oe  output  8  constant 8'b1100_0000.
- uo_out  output  8  out_sel=0: quotient; out_sel=1: {dz, 3'b000, remainder}.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - quotient = 0, remainder = 0, dz = 0.
  - busy = 0, done = 0.
  - uo_out = 0 for either out_sel.
- uo_out is combinational from the registered results and the out_sel pin. It is not registered.
- States:
  - IDLE: waiting for start.
  - RUN: iterating; count 7 down to 0.
  - DONE: results valid and held.
- Start:
  - start is level-sampled on a rising edge while in IDLE or DONE.
  - On acceptance, latch dividend and divisor, clear done, clear dz.
  - start seen in RUN is ignored; the latched operands are unaffected.
  - If start is held high, a new operation launches on every edge spent in DONE. The bench must pulse start for exactly one cycle.
- Divisor = 0 on acceptance:
  - Next state is DONE in one cycle.
  - quotient = DZ_QUOT, remainder = DZ_REM, dz = 1.
  - No RUN cycles.
- Divisor != 0:
  - Enter RUN with partial remainder R (5 bits) = 0 and count = 7.
  - Each RUN cycle:
    - T = {R[3:0], dividend[count]}.
    - If T >= {1'b0, divisor}: R = T - divisor and q[count] = 1; otherwise R = T and q[count] = 0.
  - After the count=0 iteration: go to DONE, remainder = R[3:0].
- Latency and status:
  - Start accepted at edge E0. RUN occupies edges E1..E8. done = 1 after E8.
  - That is 8 cycles from acceptance to done; 1 cycle for divide-by-zero.
  - busy = 1 exactly while in RUN.
  - busy and done are never both 1.
- Result stability:
  - Results stay stable in DONE until the next accepted start.
  - During RUN the quotient/remainder registers may show intermediate values. Consumers qualify on done.
- Arithmetic widths:
  - R never exceeds 4 bits after a subtraction, since R < divisor <= 15.
  - T needs 5 bits.
  - Quotient covers the full 0..255 range (divisor 1).
- Reset mid-operation:
  - An asynchronous rst_n assertion in any state returns immediately to the reset values.
  - No partial result is retained.
  - After release, the first start is accepted normally.

Decomposition:
- Package seq_div_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Width constants DIVIDEND_W=8, DIVISOR_W=4.
  - Pin index constants for start, out_sel, busy and done.
  - UIO_OE_VAL = 8'hC0.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: R_in[3:0], next dividend bit, divisor[3:0].
  - Outputs: R_out[3:0], q_bit.
  - Instantiated once and reused each RUN cycle.

Test Plan:
- Dividend 143, divisor 11, one-cycle start:
  - busy is high for exactly 8 cycles, then done.
  - out_sel=0 gives uo_out = 13. out_sel=1 gives 8'h00.
- Dividend 200, divisor 7:
  - Quotient 28 (8'h1C).
  - out_sel=1 gives 8'h04.
- Dividend 255, divisor 1:
  - Quotient 8'hFF, remainder 0.
- Dividend 9, divisor 15:
  - Quotient 0, remainder 9.
- Dividend 5, divisor 0:
  - done after 1 cycle, busy never asserted.
  - Quotient 8'hFF. out_sel=1 gives 8'h80.
- Control and reset corner cases:
  - Start 143/11. Raise start again with 50/3 at cycle 4 of RUN: ignored, result is still 13 r0.
  - Then start 50/3: result 16 r2.
  - Then assert rst_n=0 at RUN cycle 3: all outputs 0 immediately.
  - After release, 100/10 gives 10 r0.
